serial_subtractor: RTL

- Bit-serial two's-complement subtractor; computes A − B one bit per clock, LSB first, through a single full-subtractor cell.
- Complement of the existing combinational adder path: the same switch-driven datapath style on the DE1-SoC, but subtracting and sequential.
- Operands are loaded on a start pulse. Result, borrow and signed-overflow flags are presented with a one-cycle done pulse and held until the next start.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

    // Counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell.
// Optional macro SERIAL_SUBTRACTOR_BORROW_IN_EN adds a borrow_in port for chaining.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   res_sr;
    logic               brw;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic               borrow_init;

    logic               cell_d;
    logic               cell_bout;
    logic [WIDTH-1:0]   res_next;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    assign borrow_init = borrow_in;
`else
    assign borrow_init = 1'b0;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {cell_d, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        brw   <= borrow_init;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= res_next[WIDTH-1:1];
                    brw    <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        ready      <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= cell_bout;
                        overflow   <= (a_msb != b_msb) && (cell_d != a_msb);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
